// File: rtl/ram_dual_port_pipe_pkg.sv
// ==============================================================
// ram_pkg : shared constants and helpers for ram_dual_port_pipe
// Rev 1.0
// ==============================================================
`default_nettype none

package ram_pkg;

  localparam int RD_LAT_MIN       = 1;
  localparam int RD_LAT_MAX       = 2;
  localparam int MODE_READ_FIRST  = 0;
  localparam int MODE_WRITE_FIRST = 1;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_dual_port_pipe_if.sv
// ==============================================================
// ram_dual_port_pipe_if : write/read bus of the dual-port RAM
// Rev 1.0
// ==============================================================
`default_nettype none

interface ram_dual_port_pipe_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic                  we;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_W/8-1:0]   wbe;
  logic [DATA_W-1:0]     data_in;
  logic                  re;
  logic [ADDR_W-1:0]     raddr;
  logic [DATA_W-1:0]     data_out;
  logic                  rd_valid;
  logic                  addr_err;

  modport master (
    output we, waddr, wbe, data_in, re, raddr,
    input  data_out, rd_valid, addr_err
  );

  modport slave (
    input  we, waddr, wbe, data_in, re, raddr,
    output data_out, rd_valid, addr_err
  );

endinterface

`default_nettype wire

// File: rtl/ram_dual_port_pipe_rd_pipe.sv
// ==============================================================
// ram_rd_pipe : read-result output stage, one or two registers deep
// Rev 1.0
// ==============================================================
`default_nettype none

module ram_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;

  // Data only moves with a valid result so the output holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_data <= i_data;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_s2_valid;
      logic [DATA_W-1:0] r_s2_data;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign o_valid = r_s2_valid;
      assign o_data  = r_s2_data;
    end else begin : g_lat1
      assign o_valid = r_s1_valid;
      assign o_data  = r_s1_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ram_dual_port_pipe.sv
// ==============================================================
// ram_dual_port_pipe : parametrised simple-dual-port synchronous RAM
// Rev 1.0
// ==============================================================
`default_nettype none

module ram_dual_port_pipe
  import ram_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 16,
  parameter int RD_LAT      = 1,
  parameter int WRITE_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_dual_port_pipe_if.slave  bus
);

  localparam int              c_NBYTES = bytes_of(DATA_W);
  localparam logic [ADDR_W:0] c_DEPTH  = (ADDR_W + 1)'(DEPTH);

  generate
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $fatal(1, "ram_dual_port_pipe: RD_LAT must be 1 or 2");
    end
    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
      $fatal(1, "ram_dual_port_pipe: DATA_W must be a non-zero multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $fatal(1, "ram_dual_port_pipe: DEPTH must be in 1..2**ADDR_W");
    end
    if (WRITE_FIRST != MODE_READ_FIRST && WRITE_FIRST != MODE_WRITE_FIRST) begin : g_bad_mode
      $fatal(1, "ram_dual_port_pipe: WRITE_FIRST must be 0 or 1");
    end
  endgenerate

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_addr_err;

  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_collide;
  logic [DATA_W-1:0] w_wr_word;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_pipe_valid;
  logic [DATA_W-1:0] w_pipe_data;

  assign w_wr_in_range = ({1'b0, bus.waddr} < c_DEPTH);
  assign w_rd_in_range = ({1'b0, bus.raddr} < c_DEPTH);
  assign w_wr_ok       = bus.we && w_wr_in_range;
  assign w_rd_ok       = bus.re && w_rd_in_range;
  assign w_collide     = w_wr_ok && (bus.waddr == bus.raddr);

  // Word as it will look after this edge's write: enabled bytes replaced.
  always_comb begin
    w_wr_word = r_mem[bus.waddr];
    for (int k = 0; k < c_NBYTES; k++) begin
      if (bus.wbe[k]) begin
        w_wr_word[8*k +: 8] = bus.data_in[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[bus.waddr] <= w_wr_word;
    end
  end

  // Out-of-range reads still complete, carrying zero.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_ok) begin
      if (WRITE_FIRST == MODE_WRITE_FIRST && w_collide) begin
        w_rd_word = w_wr_word;
      end else begin
        w_rd_word = r_mem[bus.raddr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= (bus.we && !w_wr_in_range) || (bus.re && !w_rd_in_range);
    end
  end

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.re),
    .i_data  (w_rd_word),
    .o_valid (w_pipe_valid),
    .o_data  (w_pipe_data)
  );

  assign bus.data_out = w_pipe_data;
  assign bus.rd_valid = w_pipe_valid;
  assign bus.addr_err = r_addr_err;

endmodule

`default_nettype wire
